// File: rtl/bin_conv3x3_engine_pkg.sv
// bin_conv3x3_engine_pkg: shared defaults, config address map and output saturation helper
package bin_conv3x3_engine_pkg;
   localparam int IMG_W_DEF = 34;
   localparam int IMG_H_DEF = 34;
   localparam int WT_W_DEF = 8;
   localparam int OUT_W_DEF = 12;
   localparam int N_TAP = 9;
   localparam logic [3:0] CFG_BIAS = 4'd9;
   function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      return v > hi ? hi : v < lo ? lo : v;
   endfunction
endpackage

// File: rtl/bin_conv3x3_engine_if.sv
// bin_conv3x3_engine_if: config, pixel stream and result signals of the convolution engine
interface bin_conv3x3_engine_if import bin_conv3x3_engine_pkg::*; #(
   parameter int WT_W = WT_W_DEF,
   parameter int OUT_W = OUT_W_DEF
);
   logic cfg_we;
   logic [3:0] cfg_addr;
   logic signed [WT_W-1:0] cfg_data;
   logic relu_en;
   logic din_valid;
   logic sof;
   logic din;
   logic dout_valid;
   logic signed [OUT_W-1:0] dout;
   logic frame_done;
   modport master(
      output cfg_we, cfg_addr, cfg_data, relu_en, din_valid, sof, din,
      input dout_valid, dout, frame_done
   );
   modport slave(
      input cfg_we, cfg_addr, cfg_data, relu_en, din_valid, sof, din,
      output dout_valid, dout, frame_done
   );
endinterface

// File: rtl/bin_conv3x3_engine_mac.sv
// bin_conv_mac: stage 2 -- masked weight sum plus bias, optional ReLU, saturation, output register
module bin_conv_mac import bin_conv3x3_engine_pkg::*; #(
   parameter int WT_W = WT_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input logic clk,
   input logic rst,
   input logic i_v,
   input logic i_last,
   input logic i_relu,
   input logic [N_TAP-1:0] i_win,
   input logic [N_TAP:0][WT_W-1:0] i_coef,
   output logic o_valid,
   output logic signed [OUT_W-1:0] o_dout,
   output logic o_done
);
   localparam int SW = WT_W + 4;
   logic signed [SW-1:0] w_sum;
   logic signed [SW-1:0] w_rel;
   logic signed [OUT_W-1:0] w_sat;
   always_comb begin
      w_sum = SW'($signed(i_coef[CFG_BIAS]));
      for (int k = 0; k < N_TAP; k++) w_sum = w_sum + (i_win[k] ? SW'($signed(i_coef[k])) : '0);
   end
   assign w_rel = i_relu && w_sum < 0 ? '0 : w_sum;
   assign w_sat = OUT_W'(sat(32'(w_rel), OUT_W));
   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_done <= 1'b0;
         o_dout <= '0;
      end else begin
         o_valid <= i_v;
         o_done <= i_v && i_last;
         o_dout <= i_v ? w_sat : '0;
      end
   end
endmodule

// File: rtl/bin_conv3x3_engine.sv
// bin_conv3x3_engine: streaming 3x3 convolution of a binary raster image with programmable weights
module bin_conv3x3_engine import bin_conv3x3_engine_pkg::*; #(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int WT_W = WT_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input logic clk,
   input logic rst,
   bin_conv3x3_engine_if.slave bus
);
   localparam int LB_W = 2 * IMG_W + 3;
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);
   localparam logic [RW-1:0] ROW_L = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_L = CW'(IMG_W - 1);
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [RW-1:0] w_row;
   logic [CW-1:0] w_col;
   logic [LB_W-1:0] r_lb;
   logic r_v1;
   logic r_last1;
   logic [N_TAP:0][WT_W-1:0] r_coef;
   logic [N_TAP-1:0] w_win;
   assign w_row = bus.sof ? '0 : r_row;
   assign w_col = bus.sof ? '0 : r_col;
   // The shift register already holds the newest pixel at bit 0, so it doubles as the stage-1 window
   assign w_win = {r_lb[2*IMG_W+2], r_lb[2*IMG_W+1], r_lb[2*IMG_W],
                   r_lb[IMG_W+2], r_lb[IMG_W+1], r_lb[IMG_W],
                   r_lb[2], r_lb[1], r_lb[0]};
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row <= '0;
         r_col <= '0;
         r_lb <= '0;
         r_v1 <= 1'b0;
         r_last1 <= 1'b0;
         r_coef <= '0;
      end else begin
         if (bus.cfg_we && bus.cfg_addr <= CFG_BIAS) r_coef[bus.cfg_addr] <= bus.cfg_data;
         r_v1 <= bus.din_valid && w_row >= RW'(2) && w_col >= CW'(2);
         r_last1 <= bus.din_valid && w_row == ROW_L && w_col == COL_L;
         if (bus.din_valid) begin
            r_lb <= {r_lb[LB_W-2:0], bus.din};
            r_col <= w_col == COL_L ? '0 : w_col + CW'(1);
            r_row <= w_col != COL_L ? w_row : w_row == ROW_L ? '0 : w_row + RW'(1);
         end
      end
   end
   bin_conv_mac #(.WT_W(WT_W), .OUT_W(OUT_W)) u_mac (
      .clk(clk),
      .rst(rst),
      .i_v(r_v1),
      .i_last(r_last1),
      .i_relu(bus.relu_en),
      .i_win(w_win),
      .i_coef(r_coef),
      .o_valid(bus.dout_valid),
      .o_dout(bus.dout),
      .o_done(bus.frame_done)
   );
endmodule

// File: tb/tb_bin_conv3x3_engine.sv
// tb_bin_conv3x3_engine: directed frames with hand-computed results for the binary 3x3 convolution engine
`timescale 1ns/1ps
module tb_bin_conv3x3_engine;
   localparam int W = 34;
   localparam int H = 34;
   localparam int NRES = (W - 2) * (H - 2);
   logic clk = 1'b0;
   logic rst;
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int idle_bad = 0;
   int done_cnt = 0;
   int done_at = -1;
   int qa[$];
   int qb[$];
   int qref[$];
   int acc_cyc[$];
   int res_cyc[$];
   always #5 clk = ~clk;
   bin_conv3x3_engine_if #(.WT_W(8), .OUT_W(12)) ia();
   bin_conv3x3_engine_if #(.WT_W(8), .OUT_W(8)) ib();
   assign ib.cfg_we = ia.cfg_we;
   assign ib.cfg_addr = ia.cfg_addr;
   assign ib.cfg_data = ia.cfg_data;
   assign ib.relu_en = ia.relu_en;
   assign ib.din_valid = ia.din_valid;
   assign ib.sof = ia.sof;
   assign ib.din = ia.din;
   bin_conv3x3_engine #(.IMG_W(W), .IMG_H(H), .WT_W(8), .OUT_W(12)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   bin_conv3x3_engine #(.IMG_W(W), .IMG_H(H), .WT_W(8), .OUT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (ia.dout_valid) begin
         qa.push_back(int'(ia.dout));
         qb.push_back(int'(ib.dout));
         res_cyc.push_back(cyc);
      end
      if (ia.frame_done) begin
         done_cnt++;
         done_at = qa.size();
      end
      if (!ia.dout_valid && (ia.dout != 0 || ib.dout != 0)) idle_bad++;
      if (ia.frame_done && !ia.dout_valid) idle_bad++;
      if (ia.dout_valid !== ib.dout_valid) idle_bad++;
   end
   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic cfg(input logic [3:0] a, input int d);
      ia.cfg_we = 1'b1;
      ia.cfg_addr = a;
      ia.cfg_data = 8'(d);
      tick();
      ia.cfg_we = 1'b0;
   endtask
   task automatic set_coef(input int base, input int step, input int bias);
      for (int k = 0; k < 9; k++) cfg(4'(k), base + step * k);
      cfg(4'd9, bias);
   endtask
   function automatic logic pix(input int mode, input int r, input int c);
      return mode == 0 ? 1'b1 : mode == 1 ? (r == 2 && c == 2) : ((r * 5 + c * 3) % 7 < 3);
   endfunction
   task automatic send(input logic d, input logic s);
      ia.din_valid = 1'b1;
      ia.din = d;
      ia.sof = s;
      acc_cyc.push_back(cyc);
      tick();
      ia.din_valid = 1'b0;
      ia.sof = 1'b0;
      ia.din = 1'b0;
   endtask
   task automatic frame(input int mode, input bit gaps, input bit use_sof);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (gaps) repeat ($urandom_range(1)) tick();
            send(pix(mode, r, c), use_sof && r == 0 && c == 0);
         end
      repeat (4) tick();
   endtask
   task automatic clr();
      qa.delete();
      qb.delete();
      res_cyc.delete();
      acc_cyc.delete();
      done_cnt = 0;
      done_at = -1;
   endtask
   function automatic int nwrong(input int q[$], input int e);
      int n = 0;
      foreach (q[i]) if (q[i] != e) n++;
      return n;
   endfunction
   function automatic int idx(input int r, input int c);
      return (r - 2) * (W - 2) + (c - 2);
   endfunction
   initial begin
      int n;
      int j;
      rst = 1'b1;
      ia.cfg_we = 1'b0;
      ia.cfg_addr = '0;
      ia.cfg_data = '0;
      ia.relu_en = 1'b0;
      ia.din_valid = 1'b0;
      ia.sof = 1'b0;
      ia.din = 1'b0;
      repeat (3) tick();
      chk("rst_valid", ia.dout_valid, 0);
      chk("rst_dout", ia.dout, 0);
      chk("rst_done", ia.frame_done, 0);
      rst = 1'b0;
      tick();
      // all-ones frame, unit weights
      set_coef(1, 0, 0);
      clr();
      frame(0, 0, 1);
      chk("ones_cnt", qa.size(), NRES);
      chk("ones_first", qa[0], 9);
      chk("ones_wrong", nwrong(qa, 9), 0);
      chk("ones_done_cnt", done_cnt, 1);
      chk("ones_done_at", done_at, NRES);
      // single impulse at (2,2), weight k = k-4, bias 5
      set_coef(-4, 1, 5);
      clr();
      frame(1, 0, 1);
      chk("imp_cnt", qa.size(), NRES);
      chk("imp_2_2", qa[idx(2, 2)], 1);
      chk("imp_2_3", qa[idx(2, 3)], 2);
      chk("imp_3_4", qa[idx(3, 4)], 6);
      chk("imp_4_3", qa[idx(4, 3)], 8);
      chk("imp_4_4", qa[idx(4, 4)], 9);
      chk("imp_5_5", qa[idx(5, 5)], 5);
      chk("imp_not_bias", nwrong(qa, 5), 8);
      // ReLU with negative bias clamps everything
      ia.relu_en = 1'b1;
      cfg(4'd9, -10);
      clr();
      frame(1, 0, 1);
      chk("relu_cnt", qa.size(), NRES);
      chk("relu_4_4", qa[idx(4, 4)], 0);
      chk("relu_wrong", nwrong(qa, 0), 0);
      // positive saturation (raw 1270), ReLU on must pass it through
      set_coef(127, 0, 127);
      clr();
      frame(0, 0, 1);
      chk("satp_a", qa[0], 1270);
      chk("satp_b", qb[0], 127);
      chk("satp_b_wrong", nwrong(qb, 127), 0);
      // negative saturation (raw -1280)
      ia.relu_en = 1'b0;
      set_coef(-128, 0, -128);
      clr();
      frame(0, 0, 1);
      chk("satn_a", qa[0], -1280);
      chk("satn_b", qb[0], -128);
      chk("satn_b_wrong", nwrong(qb, -128), 0);
      chk("satn_cnt", qb.size(), NRES);
      // gapless vs gapped stream of the same patterned frame
      set_coef(-4, 1, 5);
      clr();
      frame(2, 0, 1);
      qref = qa;
      clr();
      frame(2, 1, 1);
      chk("gap_cnt", qa.size(), qref.size());
      n = 0;
      foreach (qa[i]) if (i < qref.size() && qa[i] != qref[i]) n++;
      chk("gap_seq", n, 0);
      chk("gap_2_3", qa[idx(2, 3)], 4);
      chk("gap_done_at", done_at, NRES);
      // sof mid-frame restarts counters
      set_coef(1, 0, 0);
      clr();
      for (int p = 0; p < 50; p++) send(1'b1, p == 0);
      clr();
      frame(0, 0, 1);
      j = -1;
      foreach (acc_cyc[i]) if (res_cyc.size() > 0 && acc_cyc[i] == res_cyc[0] - 2) j = i;
      chk("sof_lat", j + 1, 2 * W + 3);
      chk("sof_cnt", qa.size(), NRES);
      // reset at pixel (10,10) of a running frame
      clr();
      for (int p = 0; p < 10 * W + 10; p++) send(1'b1, p == 0);
      rst = 1'b1;
      ia.din_valid = 1'b1;
      ia.din = 1'b1;
      tick();
      rst = 1'b0;
      ia.din_valid = 1'b0;
      ia.din = 1'b0;
      chk("rstmid_valid", ia.dout_valid, 0);
      chk("rstmid_dout", ia.dout, 0);
      tick();
      chk("rstmid_valid2", ia.dout_valid, 0);
      clr();
      frame(0, 0, 0);
      chk("rstmid_cnt", qa.size(), NRES);
      chk("rstmid_zero", nwrong(qa, 0), 0);
      chk("rstmid_done_at", done_at, NRES);
      set_coef(1, 0, 0);
      clr();
      frame(0, 0, 1);
      chk("after_rst_wrong", nwrong(qa, 9), 0);
      chk("after_rst_cnt", qa.size(), NRES);
      chk("idle_zero", idle_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
